// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NREGS    = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_MEM
    } wb_src_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-register scoreboard: tracks registers with outstanding writes and
// raises the decode stall on a read-after-write hazard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int NREGS  = regfile_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              wr_pend,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              stall,
    output logic [NREGS-1:0]  busy
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             rs_hit;
    logic             rt_hit;

    // Set is applied after clear so a newer producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en && (clr_addr != ZERO_ADDR)) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != ZERO_ADDR)) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs_hit = (rs_addr != ZERO_ADDR) &&
                 (busy_q[rs_addr] || (wr_pend && (wr_addr == rs_addr)));
        rt_hit = (rt_addr != ZERO_ADDR) &&
                 (busy_q[rt_addr] || (wr_pend && (wr_addr == rt_addr)));
        stall  = rs_hit || rt_hit;
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port: ALU vs load
// arbitration with starvation relief, registered write controls, scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_W     = regfile_pkg::DATA_W,
    parameter int ADDR_W     = regfile_pkg::ADDR_W,
    parameter int NREGS      = regfile_pkg::NREGS,
    parameter int STARVE_MAX = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueAddr,
    input  logic              AluValid,
    input  logic [ADDR_W-1:0] AluAddr,
    input  logic [DATA_W-1:0] AluData,
    output logic              AluReady,
    input  logic              MemValid,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    output logic              MemReady,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] RsAddr,
    input  logic [ADDR_W-1:0] RtAddr,
    output logic              Stall,
    output logic [NREGS-1:0]  Busy
);

    import regfile_pkg::*;

    localparam int                CNT_W     = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    wb_src_t           grant_src;
    logic              alu_priority;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    always_comb begin
        alu_priority = (starve_q == CNT_W'(STARVE_MAX));
        grant_src    = SRC_NONE;
        if (!Reset) begin
            if (AluValid && (!MemValid || alu_priority)) begin
                grant_src = SRC_ALU;
            end else if (MemValid) begin
                grant_src = SRC_MEM;
            end
        end
    end

    assign AluReady = (grant_src == SRC_ALU);
    assign MemReady = (grant_src == SRC_MEM);

    always_comb begin
        grant_addr = MemAddr;
        grant_data = MemData;
        if (grant_src == SRC_ALU) begin
            grant_addr = AluAddr;
            grant_data = AluData;
        end
    end

    // A grant to register 0 completes the handshake but never writes.
    always_comb begin
        reg_write_d  = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if ((grant_src != SRC_NONE) && (grant_addr != ZERO_ADDR)) begin
            reg_write_d  = 1'b1;
            write_addr_d = grant_addr;
            write_data_d = grant_data;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (grant_src == SRC_ALU) begin
            starve_d = '0;
        end else if (AluValid && !alu_priority) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            starve_q     <= '0;
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            starve_q     <= starve_d;
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign RegWrite  = reg_write_q;
    assign WriteAddr = write_addr_q;
    assign WriteData = write_data_q;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_scoreboard (
        .clk      (Clock),
        .rst      (Reset),
        .set_en   (IssueValid),
        .set_addr (IssueAddr),
        .clr_en   (grant_src != SRC_NONE),
        .clr_addr (grant_addr),
        .wr_pend  (reg_write_q),
        .wr_addr  (write_addr_q),
        .rs_addr  (RsAddr),
        .rt_addr  (RtAddr),
        .stall    (Stall),
        .busy     (Busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter; expected writes are queued
// when a handshake is driven and retired by a monitor on the write port.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              IssueValid = 1'b0;
    logic [ADDR_W-1:0] IssueAddr = '0;
    logic              AluValid = 1'b0;
    logic [ADDR_W-1:0] AluAddr = '0;
    logic [DATA_W-1:0] AluData = '0;
    logic              AluReady;
    logic              MemValid = 1'b0;
    logic [ADDR_W-1:0] MemAddr = '0;
    logic [DATA_W-1:0] MemData = '0;
    logic              MemReady;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] RsAddr = '0;
    logic [ADDR_W-1:0] RtAddr = '0;
    logic              Stall;
    logic [NREGS-1:0]  Busy;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    regfile_wb_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .NREGS      (NREGS),
        .STARVE_MAX (3)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .IssueValid (IssueValid),
        .IssueAddr  (IssueAddr),
        .AluValid   (AluValid),
        .AluAddr    (AluAddr),
        .AluData    (AluData),
        .AluReady   (AluReady),
        .MemValid   (MemValid),
        .MemAddr    (MemAddr),
        .MemData    (MemData),
        .MemReady   (MemReady),
        .RegWrite   (RegWrite),
        .WriteAddr  (WriteAddr),
        .WriteData  (WriteData),
        .RsAddr     (RsAddr),
        .RtAddr     (RtAddr),
        .Stall      (Stall),
        .Busy       (Busy)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (RegWrite === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         WriteAddr, WriteData);
            end else begin
                mon_e = exp_q.pop_front();
                if ({WriteAddr, WriteData} !== {mon_e.addr, mon_e.data}) begin
                    n_fail++;
                    $display("FAIL write_port: got addr=%0d data=%h, required addr=%0d data=%h",
                             WriteAddr, WriteData, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        AluValid = 1'b1;
        AluAddr  = 5'd5;
        AluData  = 32'hA5A5_0005;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({AluReady, RegWrite, Busy, WriteAddr} !== {1'b0, 1'b0, 32'h0, 5'd0}) begin
                n_fail++;
                $display("FAIL reset_state: got ready=%b wr=%b busy=%h waddr=%0d, required 0 0 0 0",
                         AluReady, RegWrite, Busy, WriteAddr);
            end
        end
        Reset = 1'b0;
        #1;
        n_checks++;
        if (AluReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", AluReady);
        end
        exp_q.push_back('{addr: 5'd5, data: 32'hA5A5_0005});
        tick();
        AluValid = 1'b0;
        n_checks++;
        if ({RegWrite, WriteAddr} !== {1'b1, 5'd5}) begin
            n_fail++;
            $display("FAIL reset_first_write: got wr=%b addr=%0d, required wr=1 addr=5",
                     RegWrite, WriteAddr);
        end
    endtask

    task automatic test_contention();
        logic exp_alu [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        AluValid = 1'b1;
        AluAddr  = 5'd20;
        AluData  = $urandom;
        MemValid = 1'b1;
        MemAddr  = 5'd16;
        MemData  = $urandom;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if ({AluReady, MemReady} !== {exp_alu[i], !exp_alu[i]}) begin
                n_fail++;
                $display("FAIL contention_grant_%0d: got alu=%b mem=%b, required alu=%b mem=%b",
                         i, AluReady, MemReady, exp_alu[i], !exp_alu[i]);
            end
            if (exp_alu[i]) exp_q.push_back('{addr: AluAddr, data: AluData});
            else            exp_q.push_back('{addr: MemAddr, data: MemData});
            tick();
            if (exp_alu[i]) begin
                AluAddr = 5'(21 + i);
                AluData = $urandom;
            end else begin
                MemAddr = 5'(1 + i);
                MemData = $urandom;
            end
        end
        AluValid = 1'b0;
        MemValid = 1'b0;
    endtask

    task automatic test_scoreboard();
        IssueValid = 1'b1;
        IssueAddr  = 5'd8;
        tick();
        IssueValid = 1'b0;
        RsAddr     = 5'd8;
        #1;
        n_checks++;
        if ({Busy[8], Stall} !== 2'b11) begin
            n_fail++;
            $display("FAIL sb_issue: got busy8=%b stall=%b, required 1 1", Busy[8], Stall);
        end
        MemValid = 1'b1;
        MemAddr  = 5'd8;
        MemData  = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (MemReady !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_mem_ready: got %b, required 1", MemReady);
        end
        exp_q.push_back('{addr: 5'd8, data: 32'hDEAD_BEEF});
        tick();
        MemValid = 1'b0;
        n_checks++;
        if ({Busy[8], RegWrite, WriteAddr, Stall} !== {1'b0, 1'b1, 5'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL sb_t1: got busy8=%b wr=%b addr=%0d stall=%b, required 0 1 8 1",
                     Busy[8], RegWrite, WriteAddr, Stall);
        end
        tick();
        n_checks++;
        if (Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_t2_stall: got %b, required 0", Stall);
        end
        RsAddr = 5'd0;
    endtask

    task automatic test_same_edge();
        IssueValid = 1'b1;
        IssueAddr  = 5'd12;
        AluValid   = 1'b1;
        AluAddr    = 5'd12;
        AluData    = 32'h0C0C_1212;
        #1;
        n_checks++;
        if (AluReady !== 1'b1) begin
            n_fail++;
            $display("FAIL same_edge_ready: got %b, required 1", AluReady);
        end
        exp_q.push_back('{addr: 5'd12, data: 32'h0C0C_1212});
        tick();
        IssueValid = 1'b0;
        AluValid   = 1'b0;
        n_checks++;
        if (Busy !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL same_edge_busy: got %h, required 00001000", Busy);
        end
        tick();
        RtAddr = 5'd12;
        #1;
        n_checks++;
        if (Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL same_edge_rt_stall: got %b, required 1", Stall);
        end
        RtAddr = 5'd0;
    endtask

    task automatic test_zero_reg();
        AluValid = 1'b1;
        AluAddr  = 5'd0;
        AluData  = 32'h0000_1234;
        #1;
        n_checks++;
        if (AluReady !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: got %b, required 1", AluReady);
        end
        tick();
        AluValid = 1'b0;
        n_checks++;
        if (RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_no_write: got %b, required 0", RegWrite);
        end
        IssueValid = 1'b1;
        IssueAddr  = 5'd0;
        tick();
        IssueValid = 1'b0;
        RsAddr     = 5'd0;
        RtAddr     = 5'd0;
        #1;
        n_checks++;
        if ({Busy, Stall} !== {32'h0000_1000, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_busy_stall: got busy=%h stall=%b, required 00001000 0", Busy, Stall);
        end
    endtask

    task automatic test_mid_reset();
        IssueValid = 1'b1;
        IssueAddr  = 5'd3;
        tick();
        IssueValid = 1'b0;
        n_checks++;
        if (Busy[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_issue: got busy3=%b, required 1", Busy[3]);
        end
        MemValid = 1'b1;
        MemAddr  = 5'd3;
        MemData  = 32'h3333_3333;
        #1;
        n_checks++;
        if (MemReady !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_ready: got %b, required 1", MemReady);
        end
        Reset = 1'b1;
        #1;
        n_checks++;
        if (MemReady !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ready_drop: got %b, required 0", MemReady);
        end
        tick();
        n_checks++;
        if ({RegWrite, Busy, WriteAddr} !== {1'b0, 32'h0, 5'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_state: got wr=%b busy=%h addr=%0d, required 0 0 0",
                     RegWrite, Busy, WriteAddr);
        end
        Reset    = 1'b0;
        MemValid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_scoreboard();
        test_same_edge();
        test_zero_reg();
        test_mid_reset();
        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_writes: got %0d outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writeback arbiter and scoreboard for the 32x32 register file's single write port.
- Two producers compete for the port each cycle: the ALU writeback and the memory/load writeback. The block grants at most one, registers it, and drives the register file write controls (RegWrite, WriteAddr, WriteData).
- A 32-bit busy scoreboard tracks registers with outstanding writes.
- The decode stage receives a stall when it reads a busy register.

Parameters:
DATA_W, 32, writeback data width
ADDR_W, 5, register address width
NREGS, 32, number of architectural registers
STARVE_MAX, 3, consecutive ALU losses before the ALU is forced to win

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high; clears all state
IssueValid  in  1  decode issued an instruction that will write IssueAddr
IssueAddr  in  ADDR_W  destination register of the issued instruction
AluValid  in  1  ALU write request
AluAddr  in  ADDR_W  ALU destination
AluData  in  DATA_W  ALU result
AluReady  out  1  ALU request accepted this cycle
MemValid  in  1  memory write request
MemAddr  in  ADDR_W  load destination
MemData  in  DATA_W  load data
MemReady  out  1  memory request accepted this cycle
RegWrite  out  1  write enable to register file
WriteAddr  out  ADDR_W  write address to register file
WriteData  out  DATA_W  write data to register file
RsAddr  in  ADDR_W  decode read address 1
RtAddr  in  ADDR_W  decode read address 2
Stall  out  1  decode must hold
Busy  out  NREGS  scoreboard vector, bit i = register i pending

Behaviour:
Reset and clocking
- Single Clock domain. Reset is synchronous and active-high.
- While Reset is high: RegWrite=0, WriteAddr=0, WriteData=0, Busy=0, starvation counter=0, AluReady=MemReady=0.
- A request presented during Reset is dropped; the producer must re-present it.

Handshake
- A transfer occurs when Valid && Ready.
- Once Valid is asserted, Addr and Data stay stable until Ready.
- Ready is combinational from the grant in the same cycle; at most one Ready is high per cycle.

Arbitration
- Default: Mem wins.
- Starvation counter increments (saturating at STARVE_MAX) each cycle AluValid=1 and the ALU is not granted.
- When counter==STARVE_MAX and AluValid=1, the ALU wins over Mem.
- Counter returns to 0 on any ALU grant.
- If only one source is valid, it is granted.

Write output (latency 1)
- On the edge after a grant: RegWrite=1, WriteAddr/WriteData = granted request. The register file commits on the following edge.
- With no grant: RegWrite=0; WriteAddr and WriteData hold their previous values.
- Address 0: the request is accepted (Ready=1), but RegWrite stays 0 and Busy is untouched. Register 0 is never written.

Scoreboard
- Busy[IssueAddr] is set on the edge when IssueValid=1 and IssueAddr≠0.
- Busy[a] is cleared on the same edge that registers a grant to a≠0.
- If a set and a clear hit the same address on the same edge, the set wins (a newer producer exists).
- Busy[0] is always 0.

Stall (combinational)
- Stall=1 if, for either read address r (RsAddr or RtAddr) with r≠0, either:
  - Busy[r]=1, or
  - RegWrite=1 && WriteAddr==r (the register file has not committed yet).
- Stall does not affect arbitration.

Decomposition:
- Package regfile_pkg:
  - constants ADDR_W, DATA_W, NREGS, REG_ZERO=0;
  - enum wb_src_t {SRC_NONE, SRC_ALU, SRC_MEM}.
- One sub-module, regfile_scoreboard:
  - contains the busy vector, set/clear priority and Stall lookup;
  - inputs: set and clear ports plus the two read addresses.
- Arbiter, starvation counter and output registers stay in the top module.

Test Plan:
1. Reset: assert Reset for 2 cycles while AluValid=1 and AluAddr=5 -> AluReady=0, RegWrite=0, Busy=0. After Reset falls -> AluReady=1 in the first cycle; next cycle RegWrite=1, WriteAddr=5.
2. Contention: AluValid=MemValid=1 held continuously, with fresh requests after each accept -> grants are MEM, MEM, MEM, ALU, MEM, MEM, MEM, ALU (STARVE_MAX=3).
3. Scoreboard: IssueValid with IssueAddr=8, then RsAddr=8 -> Stall=1. MemValid with MemAddr=8, MemData=0xDEADBEEF granted at cycle t -> at t+1 Busy[8]=0, RegWrite=1, WriteAddr=8, Stall still 1. At t+2 Stall=0.
4. Same-edge set/clear: IssueAddr=12 issued on the same edge as an ALU grant to 12 -> Busy[12]=1 afterwards.
5. Zero register: AluValid=1, AluAddr=0, AluData=0x1234 -> AluReady=1; next cycle RegWrite=0. IssueAddr=0 -> Busy[0]=0. RsAddr=0 -> Stall=0.
6. Mid-operation reset: MemValid=1 (MemAddr=3) granted, Reset asserted on the next edge -> RegWrite=0 and Busy[3]=0 at that edge; no write reaches the register file.
